// File: rtl/dprambe_sc.sv
// Single-clock true-dual-port RAM with per-byte enables, port-A-priority collision
// arbitration, selectable read-during-write result and a built-in clear sequencer.
`timescale 1ns/1ps
module dprambe_sc #(
  parameter int unsigned          DWIDTH         = 32,
  parameter int unsigned          AWIDTH         = 10,
  parameter int unsigned          BEWIDTH        = DWIDTH / 8,
  parameter string                REGOUT         = "Y",
  parameter string                RDW_MODE       = "NEW",
  parameter string                CLEAR_ON_RESET = "Y",
  parameter logic [DWIDTH-1:0]    CLEAR_VALUE    = '0,
  parameter string                INIT_FILE      = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_req,
  output logic               init_busy,
  input  logic               wea,
  input  logic               rea,
  input  logic [AWIDTH-1:0]  addra,
  input  logic [DWIDTH-1:0]  dataa,
  input  logic [BEWIDTH-1:0] bea,
  output logic [DWIDTH-1:0]  qa,
  output logic               qa_valid,
  input  logic               web,
  input  logic               reb,
  input  logic [AWIDTH-1:0]  addrb,
  input  logic [DWIDTH-1:0]  datab,
  input  logic [BEWIDTH-1:0] beb,
  output logic [DWIDTH-1:0]  qb,
  output logic               qb_valid
);

  localparam int unsigned DEPTH   = 1 << AWIDTH;
  localparam bit          REG_OUT = (REGOUT == "Y");
  localparam bit          RDW_NEW = (RDW_MODE == "NEW");
  localparam bit          CLR_RST = (CLEAR_ON_RESET == "Y");

  if ((DWIDTH % 8) != 0 || BEWIDTH != DWIDTH / 8) begin : g_bad_width
    $error("dprambe_sc: DWIDTH must be a multiple of 8 and BEWIDTH must equal DWIDTH/8");
  end
  if (CLR_RST && INIT_FILE != "") begin : g_init_overwritten
    $warning("dprambe_sc: INIT_FILE contents are overwritten by the reset clear");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam state_t RST_STATE = CLR_RST ? S_CLEAR : S_READY;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t            state, state_d;
  logic [AWIDTH-1:0] clr_cnt, clr_cnt_d;
  logic              clr_we;
  logic              ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      clr_cnt   <= '0;
      init_busy <= CLR_RST;
    end else begin
      state     <= state_d;
      clr_cnt   <= clr_cnt_d;
      init_busy <= (state_d == S_CLEAR);
    end
  end

  // Clear walks 0..DEPTH-1 once, then parks at DEPTH-1 until the next clear_req
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    clr_we    = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == AWIDTH'(DEPTH - 1)) state_d = S_READY;
        else                               clr_cnt_d = clr_cnt + AWIDTH'(1);
      end
      S_READY: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  assign ready = (state == S_READY);

  // Port A's byte is issued last so it overrides port B on a same-address collision
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < int'(BEWIDTH); i++) begin
        if (web && beb[i]) mem[addrb][8*i +: 8] <= datab[8*i +: 8];
        if (wea && bea[i]) mem[addra][8*i +: 8] <= dataa[8*i +: 8];
      end
    end
  end

  logic [DWIDTH-1:0] rd_a, rd_b;

  // Write-first mode forwards the arbitrated write bytes onto the read word
  always_comb begin
    rd_a = mem[addra];
    rd_b = mem[addrb];
    if (RDW_NEW && ready) begin
      for (int i = 0; i < int'(BEWIDTH); i++) begin
        if (web && beb[i] && addrb == addra) rd_a[8*i +: 8] = datab[8*i +: 8];
        if (wea && bea[i])                   rd_a[8*i +: 8] = dataa[8*i +: 8];
        if (web && beb[i])                   rd_b[8*i +: 8] = datab[8*i +: 8];
        if (wea && bea[i] && addra == addrb) rd_b[8*i +: 8] = dataa[8*i +: 8];
      end
    end
  end

  logic              v1_a, v1_b;
  logic [DWIDTH-1:0] d1_a, d1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      d1_a <= '0;
      d1_b <= '0;
    end else begin
      v1_a <= ready && rea;
      v1_b <= ready && reb;
      if (ready && rea) d1_a <= rd_a;
      if (ready && reb) d1_b <= rd_b;
    end
  end

  if (REG_OUT) begin : g_regout
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        qa       <= '0;
        qb       <= '0;
        qa_valid <= 1'b0;
        qb_valid <= 1'b0;
      end else begin
        qa_valid <= v1_a;
        qb_valid <= v1_b;
        if (v1_a) qa <= d1_a;
        if (v1_b) qb <= d1_b;
      end
    end
  end else begin : g_direct
    assign qa       = d1_a;
    assign qb       = d1_b;
    assign qa_valid = v1_a;
    assign qb_valid = v1_b;
  end

endmodule

// File: tb/tb_dprambe_sc.sv
// Bench for dprambe_sc: two instances (latency 2 write-first, latency 1 read-first)
// driven in lockstep and compared every cycle against a word/byte-level memory model.
`timescale 1ns/1ps
module tb_dprambe_sc;

  localparam logic [31:0] CV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        wea, rea, web, reb;
  logic [3:0]  addra, addrb, bea, beb;
  logic [31:0] dataa, datab;

  logic        busy_y, busy_n;
  logic [31:0] qa_y, qb_y, qa_n, qb_n;
  logic        qav_y, qbv_y, qav_n, qbv_n;

  always #5 clk = ~clk;

  dprambe_sc #(.DWIDTH(32), .AWIDTH(4), .REGOUT("Y"), .RDW_MODE("NEW"),
               .CLEAR_ON_RESET("Y"), .CLEAR_VALUE(CV), .INIT_FILE("")) u_y (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy_y),
    .wea(wea), .rea(rea), .addra(addra), .dataa(dataa), .bea(bea), .qa(qa_y), .qa_valid(qav_y),
    .web(web), .reb(reb), .addrb(addrb), .datab(datab), .beb(beb), .qb(qb_y), .qb_valid(qbv_y));

  dprambe_sc #(.DWIDTH(32), .AWIDTH(4), .REGOUT("N"), .RDW_MODE("OLD"),
               .CLEAR_ON_RESET("Y"), .CLEAR_VALUE(CV), .INIT_FILE("")) u_n (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy_n),
    .wea(wea), .rea(rea), .addra(addra), .dataa(dataa), .bea(bea), .qa(qa_n), .qa_valid(qav_n),
    .web(web), .reb(reb), .addrb(addrb), .datab(datab), .beb(beb), .qb(qb_n), .qb_valid(qbv_n));

  int ncmp = 0;
  int nmis = 0;

  // Model: memory image, remaining clear words, expected outputs [dut: 0=Y,1=N][port: 0=A,1=B]
  logic [31:0] mm [16];
  int          clear_left;
  logic [31:0] eq [2][2];
  logic        ev [2][2];
  logic [31:0] pd [2];
  logic        pv [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merged(input logic [3:0] x);
    logic [31:0] w;
    w = mm[x];
    for (int i = 0; i < 4; i++) begin
      if (wea && bea[i] && addra == x)      w[8*i +: 8] = dataa[8*i +: 8];
      else if (web && beb[i] && addrb == x) w[8*i +: 8] = datab[8*i +: 8];
    end
    return w;
  endfunction

  task automatic model_reset();
    clear_left = 16;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        eq[d][p] = '0;
        ev[d][p] = 1'b0;
      end
    pd[0] = '0; pd[1] = '0;
    pv[0] = 1'b0; pv[1] = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] oldw [2];
    logic [31:0] neww [2];
    logic        acc [2];
    oldw[0] = '0; oldw[1] = '0; neww[0] = '0; neww[1] = '0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    if (clear_left > 0) begin
      mm[16 - clear_left] = CV;
      clear_left--;
    end else begin
      oldw[0] = mm[addra];
      oldw[1] = mm[addrb];
      neww[0] = merged(addra);
      neww[1] = merged(addrb);
      acc[0]  = rea;
      acc[1]  = reb;
      if (wea) mm[addra] = neww[0];
      if (web) mm[addrb] = neww[1];
      if (clear_req) clear_left = 16;
    end
    for (int p = 0; p < 2; p++) begin
      ev[0][p] = pv[p];
      if (pv[p]) eq[0][p] = pd[p];
      pv[p] = acc[p];
      if (acc[p]) pd[p] = neww[p];
      ev[1][p] = acc[p];
      if (acc[p]) eq[1][p] = oldw[p];
    end
  endtask

  task automatic chk_all();
    chk("busy_y", 32'(busy_y), 32'(clear_left > 0));
    chk("busy_n", 32'(busy_n), 32'(clear_left > 0));
    chk("qav_y", 32'(qav_y), 32'(ev[0][0]));
    chk("qbv_y", 32'(qbv_y), 32'(ev[0][1]));
    chk("qav_n", 32'(qav_n), 32'(ev[1][0]));
    chk("qbv_n", 32'(qbv_n), 32'(ev[1][1]));
    chk("qa_y", qa_y, eq[0][0]);
    chk("qb_y", qb_y, eq[0][1]);
    chk("qa_n", qa_n, eq[1][0]);
    chk("qb_n", qb_n, eq[1][1]);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle();
    clear_req = 1'b0;
    wea = 1'b0; rea = 1'b0; web = 1'b0; reb = 1'b0;
    addra = '0; addrb = '0; bea = '0; beb = '0;
    dataa = '0; datab = '0;
  endtask

  task automatic rnd_inputs();
    wea = 1'($urandom); rea = 1'($urandom); web = 1'($urandom); reb = 1'($urandom);
    addra = 4'($urandom); addrb = 4'($urandom);
    bea = 4'($urandom); beb = 4'($urandom);
    dataa = $urandom; datab = $urandom;
    clear_req = ($urandom_range(0, 63) == 0);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy_y && n < 64) begin
      wea = 1'b1; web = 1'b1; rea = 1'b1; reb = 1'b1;
      bea = 4'hF; beb = 4'hF;
      addra = 4'($urandom); addrb = 4'($urandom);
      dataa = $urandom; datab = $urandom;
      cyc();
      n++;
    end
    idle();
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    foreach (mm[i]) mm[i] = 'x;
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();

    // Clear after reset, with writes and reads attempted throughout
    rst_n = 1'b1;
    count_busy("clear_len_reset");

    // Read back every address on both ports, back to back
    for (int i = 0; i < 16; i++) begin
      rea = 1'b1; addra = 4'(i);
      reb = 1'b1; addrb = 4'(15 - i);
      cyc();
    end
    idle();
    repeat (2) cyc();
    chk("clear_val_y", qa_y, CV);
    chk("clear_val_n", qb_n, CV);

    // Byte enables
    wea = 1'b1; addra = 4'd3; dataa = 32'h11223344; bea = 4'b1111;
    cyc();
    dataa = 32'hAABBCCDD; bea = 4'b0101;
    cyc();
    idle(); rea = 1'b1; addra = 4'd3;
    cyc();
    idle();
    repeat (2) cyc();
    chk("be_y", qa_y, 32'h11BB33DD);
    chk("be_n", qa_n, 32'h11BB33DD);

    // Same-address collision
    wea = 1'b1; addra = 4'd5; dataa = 32'hAAAAAAAA; bea = 4'b0011;
    web = 1'b1; addrb = 4'd5; datab = 32'hBBBBBBBB; beb = 4'b1110;
    cyc();
    idle(); reb = 1'b1; addrb = 4'd5;
    cyc();
    idle();
    repeat (2) cyc();
    chk("coll_y", qb_y, 32'hBBBBAAAA);
    chk("coll_n", qb_n, 32'hBBBBAAAA);

    // Read-during-write from the other port
    wea = 1'b1; addra = 4'd7; dataa = 32'h0; bea = 4'hF;
    cyc();
    dataa = 32'h12345678; reb = 1'b1; addrb = 4'd7;
    cyc();
    idle();
    chk("rdw_old_v", 32'(qbv_n), 32'd1);
    chk("rdw_old_q", qb_n, 32'h0);
    chk("rdw_new_v1", 32'(qbv_y), 32'd0);
    cyc();
    chk("rdw_new_v2", 32'(qbv_y), 32'd1);
    chk("rdw_new_q", qb_y, 32'h12345678);
    chk("rdw_old_v2", 32'(qbv_n), 32'd0);

    // Back-to-back reads of 0..3 after loading distinct words
    for (int i = 0; i < 4; i++) begin
      wea = 1'b1; bea = 4'hF; addra = 4'(i); dataa = 32'hC0DE0000 + 32'(i);
      cyc();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rea = 1'b1; addra = 4'(i);
      cyc();
    end
    idle();
    repeat (2) cyc();

    // Randomised traffic, including occasional clears
    repeat (400) begin
      rnd_inputs();
      cyc();
    end
    idle();
    for (int k = 0; k < 64 && busy_y; k++) cyc();
    repeat (2) cyc();

    // Reset in the middle of a clear
    clear_req = 1'b1; rea = 1'b1; reb = 1'b1; addra = 4'd1; addrb = 4'd2;
    cyc();
    idle();
    repeat (6) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
    count_busy("clear_len_after_abort");
    cyc();

    // A requested clear takes exactly DEPTH cycles
    clear_req = 1'b1;
    cyc();
    idle();
    count_busy("clear_len_req");
    repeat (2) begin
      rnd_inputs();
      clear_req = 1'b0;
      cyc();
    end
    idle();
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
